// File: rtl/spi_master_byte_pkg.sv
// ============================================================================
// Module      : spi_master_byte_pkg
// Description : Shared state encodings, SPI mode constant and SCK divider
//               helper for the byte-level SPI master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_master_byte_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Mode 0: SCK idles low, data captured on the rising edge.
    localparam logic c_SPI_CPOL = 1'b0;

    function automatic int calc_half_div(input int clk_freq, input int spi_freq);
        return clk_freq / (2 * spi_freq);
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_master_byte_tick_gen.sv
// ============================================================================
// Module      : spi_master_byte_tick_gen
// Description : SCK half-period counter; o_tick pulses one cycle every
//               HALF_DIV enabled cycles. Counter is held at zero when disabled.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_master_byte_tick_gen #(
    parameter int HALF_DIV = 13
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_tick
);

    localparam int c_CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [c_CW-1:0] c_TERM = c_CW'(HALF_DIV - 1);

    logic [c_CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_cnt <= '0;
        end else if (r_cnt == c_TERM) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CW'(1);
        end
    end

    assign o_tick = i_en && (r_cnt == c_TERM);

endmodule

`default_nettype wire

// File: rtl/spi_master_byte.sv
// ============================================================================
// Module      : spi_master_byte
// Description : Mode-0 MSB-first SPI master, one full-duplex transfer per
//               accepted byte. Optional chip select under macro SPI_CS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_master_byte
    import spi_master_byte_pkg::*;
#(
    parameter int CLK_FREQ = 27_000_000,
    parameter int SPI_FREQ = 1_000_000,
    parameter int DATA_W   = 8,
    parameter int HALF_DIV = calc_half_div(CLK_FREQ, SPI_FREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              spi_clk,
    output logic              spi_mosi,
    input  logic              spi_miso
`ifdef SPI_CS_EN
   ,output logic              spi_cs_n
`endif
);

    localparam int c_BW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [c_BW-1:0] c_LAST = c_BW'(DATA_W - 1);

    state_t            r_state;
    logic [DATA_W-2:0] r_tx_sr;    // bits still to send; MSB is driven on accept
    logic [DATA_W-1:0] r_rx_sr;
    logic [c_BW-1:0]   r_bit_cnt;
    logic              w_tick;
    logic              w_shift_en;

    assign w_shift_en = (r_state == ST_SHIFT);

    spi_master_byte_tick_gen #(
        .HALF_DIV (HALF_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_shift_en),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            tx_ready  <= 1'b1;
            rx_valid  <= 1'b0;
            rx_data   <= '0;
            spi_clk   <= c_SPI_CPOL;
            spi_mosi  <= 1'b0;
            r_tx_sr   <= '0;
            r_rx_sr   <= '0;
            r_bit_cnt <= '0;
`ifdef SPI_CS_EN
            spi_cs_n  <= 1'b1;
`endif
        end else begin
            rx_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        r_tx_sr   <= tx_data[DATA_W-2:0];
                        spi_mosi  <= tx_data[DATA_W-1];
                        r_bit_cnt <= '0;
                        tx_ready  <= 1'b0;
                        r_state   <= ST_SHIFT;
`ifdef SPI_CS_EN
                        spi_cs_n  <= 1'b0;
`endif
                    end
                end
                ST_SHIFT: begin
                    if (w_tick) begin
                        spi_clk <= ~spi_clk;
                        if (!spi_clk) begin
                            r_rx_sr <= {r_rx_sr[DATA_W-2:0], spi_miso};
                        end else if (r_bit_cnt == c_LAST) begin
                            // Result is published as the last falling edge lands.
                            r_state  <= ST_DONE;
                            rx_valid <= 1'b1;
                            rx_data  <= r_rx_sr;
                            spi_mosi <= 1'b0;
                        end else begin
                            spi_mosi  <= r_tx_sr[DATA_W-2];
                            r_tx_sr   <= {r_tx_sr[DATA_W-3:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt + c_BW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    r_state  <= ST_IDLE;
                    tx_ready <= 1'b1;
`ifdef SPI_CS_EN
                    spi_cs_n <= 1'b1;
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_master_byte.sv
// ============================================================================
// Module      : tb_spi_master_byte
// Description : Self-checking bench for spi_master_byte against a transfer
//               timeline model. Checks spi_cs_n too when SPI_CS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_master_byte;

    localparam int HD = 13;
    localparam int W  = 8;
    localparam int T  = 2 * HD * W;   // accept edge to final falling SCK edge

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] tx_data = '0;
    logic         tx_valid = 1'b0;
    logic         tx_ready;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         spi_clk;
    logic         spi_mosi;
    logic         spi_miso;
    logic         rnd_bit = 1'b0;
    int           miso_mode = 0;      // 0: tied high, 1: loopback, 2: random
`ifdef SPI_CS_EN
    logic         spi_cs_n;
`endif

    assign spi_miso = (miso_mode == 1) ? spi_mosi : (miso_mode == 0) ? 1'b1 : rnd_bit;

    spi_master_byte #(
        .CLK_FREQ (27_000_000),
        .SPI_FREQ (1_000_000),
        .DATA_W   (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
`ifdef SPI_CS_EN
       ,.spi_cs_n (spi_cs_n)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, exp, $time);
        end
    endtask

    // Timeline model: offset k = posedges since the accept edge.
    int           cyc = 0;
    logic         m_active = 1'b0;
    int           m_k = 0;
    logic [W-1:0] m_d = '0;
    logic [W-1:0] m_rx = '0;
    logic [W-1:0] exp_rx = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_active <= 1'b0;
            m_k      <= 0;
            exp_rx   <= '0;
        end else if (m_active) begin
            if ((m_k % (2 * HD)) == HD - 1 && m_k < T)
                m_rx <= {m_rx[W-2:0], spi_miso};
            if (m_k + 1 == T)
                exp_rx <= m_rx;
            if (m_k + 1 == T + 1)
                m_active <= 1'b0;
            else
                m_k <= m_k + 1;
        end else if (tx_valid) begin
            m_active <= 1'b1;
            m_k      <= 0;
            m_d      <= tx_data;
            m_rx     <= '0;
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("spi_clk",  {31'b0, spi_clk},
                  {31'b0, m_active && m_k < T && ((m_k / HD) % 2 == 1)});
            check("spi_mosi", {31'b0, spi_mosi},
                  {31'b0, (m_active && m_k < T) ? m_d[W-1-m_k/(2*HD)] : 1'b0});
            check("tx_ready", {31'b0, tx_ready}, {31'b0, !m_active});
            check("rx_valid", {31'b0, rx_valid}, {31'b0, m_active && m_k == T});
            check("rx_data",  {24'b0, rx_data}, {24'b0, exp_rx});
`ifdef SPI_CS_EN
            check("spi_cs_n", {31'b0, spi_cs_n}, {31'b0, !m_active});
`endif
        end
    end

    // Event log for the hand-computed expectations.
    int           rx_cyc_q[$];
    logic [W-1:0] rx_dat_q[$];
    int           rise_cyc_q[$];
    logic         rise_mosi_q[$];
    logic         prev_sck = 1'b0;

    always @(negedge clk) begin
        prev_sck <= spi_clk;
        if (spi_clk === 1'b1 && prev_sck === 1'b0) begin
            rise_cyc_q.push_back(cyc);
            rise_mosi_q.push_back(spi_mosi);
        end
        if (rx_valid === 1'b1) begin
            rx_cyc_q.push_back(cyc);
            rx_dat_q.push_back(rx_data);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            rnd_bit = 1'($urandom % 2);
        end
    end

    int acc_cyc = 0;

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [W-1:0] d);
        int guard;
        guard = 0;
        while (tx_ready !== 1'b1 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) check("send_timeout", 32'd1, 32'd0);
        tx_data  = d;
        tx_valid = 1'b1;
        acc_cyc  = cyc + 1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n);
        int guard;
        guard = 0;
        while (rx_cyc_q.size() < n && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) check("rx_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int           base_rx;
    int           base_rise;
    logic [W-1:0] bits;
    logic [W-1:0] d;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_tx_ready", {31'b0, tx_ready}, 32'd1);
        check("reset_spi_clk",  {31'b0, spi_clk},  32'd0);
        check("reset_rx_valid", {31'b0, rx_valid}, 32'd0);
        check("reset_rx_data",  {24'b0, rx_data},  32'd0);
        check("reset_mosi",     {31'b0, spi_mosi}, 32'd0);
`ifdef SPI_CS_EN
        check("reset_cs_n",     {31'b0, spi_cs_n}, 32'd1);
`endif
        rst = 1'b0;
        idle(2);

        // miso tied high, 0x3C
        miso_mode = 0;
        base_rx   = rx_cyc_q.size();
        base_rise = rise_cyc_q.size();
        send(8'h3C);
        wait_rx(base_rx + 1);
        check("t1_latency", rx_cyc_q[base_rx] + 1 - acc_cyc, 32'd209);
        check("t1_rx_data", {24'b0, rx_dat_q[base_rx]}, 32'hFF);
        check("t1_rises", rise_cyc_q.size() - base_rise, 32'd8);
        bits = '0;
        for (int i = 0; i < W; i++) bits = {bits[W-2:0], rise_mosi_q[base_rise+i]};
        check("t1_mosi_bits", {24'b0, bits}, 32'h3C);
        idle(3);

        // loopback, 0xA5
        miso_mode = 1;
        base_rx   = rx_cyc_q.size();
        base_rise = rise_cyc_q.size();
        send(8'hA5);
        wait_rx(base_rx + 1);
        check("t2_rx_data", {24'b0, rx_dat_q[base_rx]}, 32'hA5);
        check("t2_rises", rise_cyc_q.size() - base_rise, 32'd8);
        check("t2_sck_period", rise_cyc_q[base_rise+1] - rise_cyc_q[base_rise], 32'd26);
        check("t2_first_rise", rise_cyc_q[base_rise] - acc_cyc, 32'd13);
        idle(4);

        // back-to-back with tx_valid held
        base_rx  = rx_cyc_q.size();
        tx_data  = 8'h01;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data  = 8'h80;
        while (tx_ready !== 1'b1 && rx_cyc_q.size() < base_rx + 1) @(negedge clk);
        wait_rx(base_rx + 1);
        while (tx_ready === 1'b1) @(negedge clk);
        tx_valid = 1'b0;
        wait_rx(base_rx + 2);
        check("t3_spacing", rx_cyc_q[base_rx+1] - rx_cyc_q[base_rx], 32'd210);
        check("t3_first",  {24'b0, rx_dat_q[base_rx]},   32'h01);
        check("t3_second", {24'b0, rx_dat_q[base_rx+1]}, 32'h80);
        idle(5);

        // tx_valid while busy is ignored
        base_rx = rx_cyc_q.size();
        send(8'h5A);
        idle(48);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_rx(base_rx + 1);
        idle(300);
        check("t4_count", rx_cyc_q.size() - base_rx, 32'd1);
        check("t4_data", {24'b0, rx_dat_q[base_rx]}, 32'h5A);

        // reset mid-transfer
        base_rx = rx_cyc_q.size();
        send(8'hC3);
        idle(98);
        rst = 1'b1;
        @(negedge clk);
        check("t5_spi_clk",  {31'b0, spi_clk},  32'd0);
        check("t5_tx_ready", {31'b0, tx_ready}, 32'd1);
`ifdef SPI_CS_EN
        check("t5_cs_n",     {31'b0, spi_cs_n}, 32'd1);
`endif
        rst = 1'b0;
        idle(300);
        check("t5_no_rx", rx_cyc_q.size() - base_rx, 32'd0);

        // randomized transfers
        for (int n = 0; n < 12; n++) begin
            miso_mode = 1 + int'($urandom % 2);
            d = 8'($urandom);
            base_rx = rx_cyc_q.size();
            idle(int'($urandom_range(0, 5)));
            send(d);
            if ($urandom % 2 == 1) begin
                idle(int'($urandom_range(1, 150)));
                tx_data  = 8'($urandom);
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
            end
            wait_rx(base_rx + 1);
            if (miso_mode == 1)
                check("rnd_loopback", {24'b0, rx_dat_q[base_rx]}, {24'b0, d});
        end
        idle(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        check("global_timeout", 32'd1, 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
